// File: rtl/alu_vec_sequencer.sv
// Vector sequencer that streams element pairs through the lane ALU.
// Optional macro ALU_SEQ_CNT_EN adds a saturating elem_cnt output.
module alu_vec_sequencer #(
  parameter int DATA_W = 21,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_funct,
  input  logic [LEN_W-1:0]  in_len,
  input  logic [ADDR_W-1:0] in_src1,
  input  logic [ADDR_W-1:0] in_src2,
  input  logic [ADDR_W-1:0] in_dst,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  input  logic [DATA_W-1:0] rd_data1,
  input  logic [DATA_W-1:0] rd_data2,
  output logic              alu_flag,
  output logic [2:0]        alu_funct,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
`ifdef ALU_SEQ_CNT_EN
  output logic              err,
  output logic [15:0]       elem_cnt
`else
  output logic              err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [2:0]        funct_q;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] src1_q;
  logic [ADDR_W-1:0] src2_q;
  logic [ADDR_W-1:0] dst_q;
  logic              err_q;
  logic [LEN_W-1:0]  idx;
  logic              ex_vld;
  logic [ADDR_W-1:0] ex_addr;

  logic accept;
  logic legal;
  logic last_rd;

  assign accept  = in_valid && (state == S_IDLE);
  assign last_rd = (idx == len_q - LEN_W'(1));

  // Decode which function codes the lane ALU supports
  always_comb begin
    legal = 1'b0;
    unique case (in_funct)
      3'b000:  legal = 1'b1;
      3'b010:  legal = 1'b1;
      3'b011:  legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (!legal)            state_nxt = S_DONE;
          else if (in_len == '0) state_nxt = S_DONE;
          else                   state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (last_rd) state_nxt = S_DRAIN;
      end
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Latched instruction, read index and exec-stage valid/address
  always_ff @(posedge clk) begin
    if (rst) begin
      funct_q <= '0;
      len_q   <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      dst_q   <= '0;
      err_q   <= 1'b0;
      idx     <= '0;
      ex_vld  <= 1'b0;
      ex_addr <= '0;
    end else begin
      if (accept) begin
        funct_q <= in_funct;
        len_q   <= in_len;
        src1_q  <= in_src1;
        src2_q  <= in_src2;
        dst_q   <= in_dst;
        err_q   <= !legal;
        idx     <= '0;
      end else if (state == S_RUN) begin
        idx <= idx + LEN_W'(1);
      end
      ex_vld <= (state == S_RUN);
      if (state == S_RUN) ex_addr <= dst_q + ADDR_W'(idx);
      else                ex_addr <= '0;
    end
  end

  // Outputs: read port in RUN, ALU drive and writeback from exec stage
  always_comb begin
    in_ready  = (state == S_IDLE);
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    err       = (state == S_DONE) && err_q;
    rd_en     = (state == S_RUN);
    rd_addr1  = '0;
    rd_addr2  = '0;
    alu_flag  = ex_vld;
    alu_funct = funct_q;
    alu_op1   = '0;
    alu_op2   = '0;
    wr_en     = ex_vld;
    wr_addr   = '0;
    wr_data   = '0;
    if (state == S_RUN) begin
      rd_addr1 = src1_q + ADDR_W'(idx);
      rd_addr2 = src2_q + ADDR_W'(idx);
    end
    if (ex_vld) begin
      alu_op1 = rd_data1;
      alu_op2 = rd_data2;
      wr_addr = ex_addr;
      wr_data = alu_result;
    end
  end

`ifdef ALU_SEQ_CNT_EN
  // Count written elements, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst)
      elem_cnt <= '0;
    else if (wr_en && (elem_cnt != 16'hFFFF))
      elem_cnt <= elem_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/alu_vec_sequencer.md
Name: alu_vec_sequencer

Overview:
Sequences the lane ALU (21-bit move/add/sub, enabled by flag, selected by 3-bit funct) over whole vectors. Accepts one vector instruction through a valid/ready handshake. Streams element pairs from the element memory through the ALU and writes the results back at one element per cycle. Sits between instruction decode and the lane datapath and owns the ALU flag/funct controls.

Parameters:
DATA_W, 21, element and ALU operand width
ADDR_W, 8, element memory address width
LEN_W, 6, width of the vector length field

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  instruction valid
in_ready  out  1  sequencer can accept an instruction (high only in IDLE)
in_funct  in  3  000 move, 010 add, 011 sub; all other codes are illegal
in_len  in  LEN_W  element count, 0..2^LEN_W-1
in_src1  in  ADDR_W  base address of operand 1 vector
in_src2  in  ADDR_W  base address of operand 2 vector
in_dst  in  ADDR_W  base address of result vector
rd_en  out  1  element memory read strobe
rd_addr1  out  ADDR_W  operand 1 read address
rd_addr2  out  ADDR_W  operand 2 read address
rd_data1  in  DATA_W  operand 1 data, valid the cycle after rd_en
rd_data2  in  DATA_W  operand 2 data, valid the cycle after rd_en
alu_flag  out  1  ALU enable
alu_funct  out  3  ALU function select
alu_op1  out  DATA_W  ALU operand 1
alu_op2  out  DATA_W  ALU operand 2
alu_result  in  DATA_W  ALU combinational result
wr_en  out  1  result write strobe
wr_addr  out  ADDR_W  result write address
wr_data  out  DATA_W  result write data
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  qualified by done; high when the instruction was illegal

Behaviour:
- Reset: clk and rst only; rst is synchronous and active-high. The edge that samples rst=1 enters IDLE and clears the index, the exec-stage valid bit and the latched instruction.
- Reset output values: in_ready=1, busy=0, done=0, err=0, rd_en=0, wr_en=0, alu_flag=0. alu_funct, alu_op1, alu_op2, rd_addr*, wr_addr and wr_data are 0.
- Reset mid-operation: in-flight elements are dropped. No wr_en and no done after the reset edge.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch funct/len/src1/src2/dst and set idx=0.
  - Illegal funct -> DONE with err latched to 1.
  - len=0 -> DONE with err=0.
  - Otherwise -> RUN.
- RUN: rd_en=1, rd_addr1=src1+idx, rd_addr2=src2+idx, idx++. When idx==len-1 is issued -> DRAIN.
- Exec stage: a registered valid bit ex_vld with address ex_addr=dst+idx_of_read.
  - alu_flag=ex_vld, alu_funct=latched funct.
  - alu_op1=rd_data1 and alu_op2=rd_data2 when ex_vld, else 0.
  - wr_en=ex_vld, wr_addr=ex_addr, wr_data=alu_result (same cycle; ALU is combinational).
- DRAIN: no read; the last element writes this cycle -> DONE.
- DONE: done=1 for one cycle, err as latched -> IDLE.
- Timing: accept at cycle 0. Reads at cycles 1..len, writes at 2..len+1, done at len+2, in_ready at len+3.
- Throughput: one element/cycle; no bubbles within an instruction. Minimum instruction spacing is len+3 cycles.
- Address arithmetic: modulo 2^ADDR_W; wraps silently.
- Data arithmetic: DATA_W wide, done in the ALU; the sequencer neither checks nor extends it.
- in_* are ignored outside IDLE. in_valid held high across DONE is accepted at the first IDLE cycle.
- err=0 whenever done=0.

Optional Feature:
ALU_SEQ_CNT_EN:
- With the macro defined: adds output elem_cnt (16 bits). It increments on every wr_en, saturates at 0xFFFF and clears on rst.
- Without the macro: the port and its counter are absent.

Test Plan:
- Add: mem[0x10..0x13]=1,2,3,4; mem[0x20..0x23]=10,20,30,40; funct 010, len 4, dst 0x30.
  -> rd_en at cycles 1-4; wr_en at cycles 2-5 writing 11,22,33,44 to 0x30..0x33; done=1, err=0 at cycle 6; in_ready=1 at cycle 7.
- Sub wrap: op1=0, op2=1, funct 011, len 1 -> wr_data=0x1FFFFF; move funct 000 with op2=0x0ABCD -> wr_data=0x0ABCD.
- Boundary: len=0 -> no rd_en/wr_en, done at cycle 1. Illegal funct 001, len 5 -> no rd_en/wr_en, done=1 with err=1 at cycle 1.
- Address wrap: src1=0xFE, len 4 -> rd_addr1 sequence 0xFE,0xFF,0x00,0x01; dst=0xFF -> wr_addr 0xFF,0x00,0x01,0x02.
- Back-to-back: in_valid held with two len-2 instructions -> second accepted exactly at cycle 5 (first IDLE), no overlap of writes.
- Reset mid-run: len 8, assert rst for one cycle after 2 writes -> no further wr_en/done; in_ready=1 the cycle after the reset edge; a new instruction then runs correctly.
